// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the 2-way write-back L1 data cache controller.
package dcache_controller_pkg;

    localparam int NUM_SETS   = 16;
    localparam int LINE_BITS  = 256;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 4;
    localparam int TAG_W      = 23;
    localparam int ENTRY_W    = 25;
    localparam int WORD_SEL_W = 3;

    // Tag entry layout: {valid, dirty, tag[22:0]}
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    // Miss-handling FSM encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_MISS       = 3'd1;
    localparam logic [2:0] ST_READMISS   = 3'd2;
    localparam logic [2:0] ST_READMISSOK = 3'd3;
    localparam logic [2:0] ST_WRITEBACK  = 3'd4;

    // Extract 32-bit word 'sel' from a cache line.
    function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0]  line,
                                             input logic [WORD_SEL_W-1:0] sel);
        return line[32*int'(sel) +: 32];
    endfunction

    // Return 'line' with 32-bit word 'sel' replaced by 'word'.
    function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0]  line,
                                                      input logic [WORD_SEL_W-1:0] sel,
                                                      input logic [31:0]           word);
        logic [LINE_BITS-1:0] res;
        res = line;
        res[32*int'(sel) +: 32] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_sram_2way.sv
// Tag/data/LRU storage for the 2-way cache, with hit compare and victim selection.
module dcache_sram_2way
    import dcache_controller_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    index_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [WORD_SEL_W-1:0] word_i,
    input  logic [31:0]           wdata_i,
    input  logic                  req_i,
    input  logic                  store_i,
    input  logic                  refill_i,
    input  logic [LINE_BITS-1:0]  refill_line_i,
    output logic                  hit_o,
    output logic [LINE_BITS-1:0]  hit_line_o,
    output logic [ENTRY_W-1:0]    victim_entry_o,
    output logic [LINE_BITS-1:0]  victim_line_o
);

    logic [ENTRY_W-1:0]   tag_q  [NUM_SETS][2];
    logic [ENTRY_W-1:0]   tag_d  [NUM_SETS][2];
    logic [LINE_BITS-1:0] data_q [NUM_SETS][2];
    logic [LINE_BITS-1:0] data_d [NUM_SETS][2];
    logic [NUM_SETS-1:0]  lru_q;
    logic [NUM_SETS-1:0]  lru_d;

    logic [ENTRY_W-1:0] entry0;
    logic [ENTRY_W-1:0] entry1;
    logic               match0;
    logic               match1;
    logic               hit_way;
    logic               victim_way;

    assign entry0 = tag_q[index_i][0];
    assign entry1 = tag_q[index_i][1];
    assign match0 = entry0[VALID_BIT] && (entry0[TAG_W-1:0] == tag_i);
    assign match1 = entry1[VALID_BIT] && (entry1[TAG_W-1:0] == tag_i);

    assign hit_o      = req_i && (match0 || match1);
    assign hit_way    = ~match0;
    assign hit_line_o = data_q[index_i][hit_way];

    // Fill an invalid way first (way0 preferred); otherwise evict the LRU way.
    assign victim_way     = !entry0[VALID_BIT] ? 1'b0 :
                            !entry1[VALID_BIT] ? 1'b1 : lru_q[index_i];
    assign victim_entry_o = tag_q[index_i][victim_way];
    assign victim_line_o  = data_q[index_i][victim_way];

    // Next-state of the arrays: store-hit merge, LRU update and line refill.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path leaves it unassigned (no latch).
        tag_d  = tag_q;
        data_d = data_q;
        lru_d  = lru_q;
        if (hit_o) begin
            lru_d[index_i] = ~hit_way;
            if (store_i) begin
                data_d[index_i][hit_way] = put_word(data_q[index_i][hit_way], word_i, wdata_i);
                tag_d[index_i][hit_way][DIRTY_BIT] = 1'b1;
            end
        end else if (refill_i) begin
            tag_d[index_i][victim_way]  = {1'b1, 1'b0, tag_i};
            data_d[index_i][victim_way] = refill_line_i;
        end
    end

    // Storage registers; the whole array clears on reset so every line starts invalid and zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the data array is reset too, since its contents must read back as zero after reset.
        if (rst_i) begin
            tag_q  <= '{default: '0};
            data_q <= '{default: '0};
            lru_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
            tag_q  <= tag_d;
            data_q <= data_d;
            lru_q  <= lru_d;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// 2-way set-associative write-back L1 data cache controller: hit path, miss FSM
// and single-outstanding refill / write-back handshake with line memory.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);

    logic [2:0]           state_q,      state_d;
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q,  mem_write_d;
    logic [31:0]          mem_addr_q,   mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q,   mem_data_d;
    logic                 refill_we;

    logic                 req;
    logic                 hit;
    logic [INDEX_W-1:0]   index;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] hit_line;
    logic [ENTRY_W-1:0]   victim_entry;
    logic [LINE_BITS-1:0] victim_line;
    logic                 unused_byte_sel;

    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign index           = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign tag             = cpu_addr_i[31 -: TAG_W];
    assign unused_byte_sel = ^cpu_addr_i[1:0];

    dcache_sram_2way u_sram (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .index_i        (index),
        .tag_i          (tag),
        .word_i         (cpu_addr_i[4:2]),
        .wdata_i        (cpu_data_i),
        .req_i          (req),
        .store_i        (cpu_MemWrite_i),
        .refill_i       (refill_we),
        .refill_line_i  (mem_data_i),
        .hit_o          (hit),
        .hit_line_o     (hit_line),
        .victim_entry_o (victim_entry),
        .victim_line_o  (victim_line)
    );

    assign cpu_stall_o  = req & ~hit;
    assign cpu_data_o   = hit ? get_word(hit_line, cpu_addr_i[4:2]) : 32'h0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Miss FSM: decide write-back vs refill, then wait for each memory ack in turn.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        refill_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !hit) state_d = ST_MISS;
            end
            ST_MISS: begin
                mem_enable_d = 1'b1;
                if (victim_entry[VALID_BIT] && victim_entry[DIRTY_BIT]) begin
                    state_d     = ST_WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {victim_entry[TAG_W-1:0], index, {OFFSET_W{1'b0}}};
                    mem_data_d  = victim_line;
                end else begin
                    state_d     = ST_READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = ST_READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {cpu_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            ST_READMISS: begin
                if (mem_ack_i) begin
                    state_d      = ST_READMISSOK;
                    mem_enable_d = 1'b0;
                    refill_we    = 1'b1;
                end
            end
            ST_READMISSOK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered memory-request outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed testbench for dcache_controller with a fixed-latency line-memory model.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    localparam int MEM_LAT = 2;
    // Stall cycles seen at negedges: IDLE + MISS + MEM_LAT (clean), plus MEM_LAT more for a write-back.
    localparam int CLEAN_STALL = 4;
    localparam int DIRTY_STALL = 6;

    localparam logic [255:0] LINE0     = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] LINE0_MOD = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_DEAD_BEEF_EEEE_FFFF;
    localparam logic [255:0] LINE200   = 256'h2000_0007_2000_0006_2000_0005_2000_0004_2000_0003_2000_0002_2000_0001_2000_0000;
    localparam logic [255:0] LINE400   = 256'h4000_0007_4000_0006_4000_0005_4000_0004_4000_0003_4000_0002_4000_0001_E00E_F00F;
    localparam logic [255:0] LINE420   = 256'h4200_0007_4200_0006_4200_0005_4200_0004_4200_0003_4200_0002_4200_0001_4200_CAFE;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int n_vec = 0;
    int n_err = 0;

    // Memory model state (written only by the responder process)
    logic [255:0] mem_model [1024];
    int           rd_count     = 0;
    int           wb_count     = 0;
    int           write_cycles = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;
    logic         mem_auto     = 1'b1;
    logic         force_ack    = 1'b0;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line memory: acks MEM_LAT cycles after a request appears; a write stores the line.
    initial begin : mem_responder
        int wait_cnt;
        for (int i = 0; i < 1024; i++) mem_model[i] = '0;
        mem_model[0]  = LINE0;
        mem_model[16] = LINE200;
        mem_model[32] = LINE400;
        mem_model[33] = LINE420;
        wait_cnt   = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_enable_o && mem_write_o) write_cycles++;
            if (!mem_auto) begin
                mem_ack_i = force_ack;
                wait_cnt  = 0;
            end else begin
                mem_ack_i = 1'b0;
                if (rst_i || !mem_enable_o) begin
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt == MEM_LAT) begin
                        if (mem_write_o) begin
                            mem_model[mem_addr_o[14:5]] = mem_data_o;
                            last_wb_addr = mem_addr_o;
                            last_wb_data = mem_data_o;
                            wb_count++;
                        end else begin
                            mem_data_i = mem_model[mem_addr_o[14:5]];
                            rd_count++;
                        end
                        mem_ack_i = 1'b1;
                        wait_cnt  = 0;
                    end
                end
            end
        end
    end

    // Issue one CPU access, hold it while stalled, return stall count and data seen on the hit cycle.
    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int stalls,
                          output logic [31:0] rdata, output logic timed_out);
        @(negedge clk_i);
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        stalls    = 0;
        rdata     = '0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!cpu_stall_o) begin
                rdata     = cpu_data_o;
                timed_out = 1'b0;
                break;
            end
            stalls++;
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        n_vec++; if (mem_enable_o !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", mem_enable_o); end
        n_vec++; if (mem_write_o !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", mem_write_o); end
        n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        n_vec++; if (mem_data_o !== 256'h0) begin n_err++; $display("FAIL reset_mem_data: got %h want 0", mem_data_o); end
        n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
        n_vec++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL reset_cpu_data: got %h want 0", cpu_data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_cold_load();
        int st; logic [31:0] q; logic to; int rd0, wc0;
        rd0 = rd_count; wc0 = write_cycles;
        cpu_op(1'b1, 1'b0, 32'h000, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL cold_timeout: request never completed"); end
        n_vec++; if (st != CLEAN_STALL) begin n_err++; $display("FAIL cold_stall: got %0d want %0d", st, CLEAN_STALL); end
        n_vec++; if (q !== 32'hEEEEFFFF) begin n_err++; $display("FAIL cold_data: got %h want eeeeffff", q); end
        n_vec++; if (dut.u_sram.tag_q[0][0][VALID_BIT:DIRTY_BIT] !== 2'b10) begin n_err++; $display("FAIL cold_entry_vd: got %b want 10", dut.u_sram.tag_q[0][0][VALID_BIT:DIRTY_BIT]); end
        n_vec++; if (write_cycles - wc0 != 0 || rd_count - rd0 != 1) begin n_err++; $display("FAIL cold_mem_traffic: writes %0d reads %0d want 0 1", write_cycles - wc0, rd_count - rd0); end
    endtask

    task automatic test_load_hit();
        int st; logic [31:0] q; logic to;
        cpu_op(1'b1, 1'b0, 32'h01C, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0 || st != 0) begin n_err++; $display("FAIL hit_stall: got %0d (timeout %b) want 0", st, to); end
        n_vec++; if (q !== 32'h00001111) begin n_err++; $display("FAIL hit_data: got %h want 00001111", q); end
        n_vec++; if (dut.u_sram.lru_q[0] !== 1'b1) begin n_err++; $display("FAIL hit_lru: got %b want 1", dut.u_sram.lru_q[0]); end
    endtask

    task automatic test_store_hit();
        int st; logic [31:0] q; logic to; int wc0;
        wc0 = write_cycles;
        // Both request lines high: treated as a store.
        cpu_op(1'b1, 1'b1, 32'h004, 32'hDEADBEEF, st, q, to);
        n_vec++; if (to !== 1'b0 || st != 0) begin n_err++; $display("FAIL store_stall: got %0d (timeout %b) want 0", st, to); end
        n_vec++; if (dut.u_sram.data_q[0][0] !== LINE0_MOD) begin n_err++; $display("FAIL store_line: got %h want %h", dut.u_sram.data_q[0][0], LINE0_MOD); end
        n_vec++; if (dut.u_sram.tag_q[0][0][DIRTY_BIT] !== 1'b1) begin n_err++; $display("FAIL store_dirty: got %b want 1", dut.u_sram.tag_q[0][0][DIRTY_BIT]); end
        n_vec++; if (mem_model[0] !== LINE0 || write_cycles != wc0) begin n_err++; $display("FAIL store_mem_untouched: got %h want %h", mem_model[0], LINE0); end
    endtask

    task automatic test_writeback();
        int st; logic [31:0] q; logic to; int rd0, wb0;
        cpu_op(1'b1, 1'b0, 32'h200, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0 || st != CLEAN_STALL) begin n_err++; $display("FAIL fill200_stall: got %0d want %0d", st, CLEAN_STALL); end
        n_vec++; if (q !== 32'h20000000) begin n_err++; $display("FAIL fill200_data: got %h want 20000000", q); end
        n_vec++; if (dut.u_sram.lru_q[0] !== 1'b0) begin n_err++; $display("FAIL fill200_lru: got %b want 0", dut.u_sram.lru_q[0]); end
        rd0 = rd_count; wb0 = wb_count;
        cpu_op(1'b1, 1'b0, 32'h400, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0 || st != DIRTY_STALL) begin n_err++; $display("FAIL wb_stall: got %0d want %0d", st, DIRTY_STALL); end
        n_vec++; if (q !== 32'hE00EF00F) begin n_err++; $display("FAIL wb_load_data: got %h want e00ef00f", q); end
        n_vec++; if (wb_count - wb0 != 1 || last_wb_addr !== 32'h000) begin n_err++; $display("FAIL wb_addr: got %h (count %0d) want 00000000 (1)", last_wb_addr, wb_count - wb0); end
        n_vec++; if (last_wb_data !== LINE0_MOD) begin n_err++; $display("FAIL wb_data: got %h want %h", last_wb_data, LINE0_MOD); end
        n_vec++; if (rd_count - rd0 != 1) begin n_err++; $display("FAIL wb_refills: got %0d want 1", rd_count - rd0); end
        n_vec++; if (dut.u_sram.tag_q[0][0] !== {2'b10, 23'd2}) begin n_err++; $display("FAIL wb_way0_entry: got %h want %h", dut.u_sram.tag_q[0][0], {2'b10, 23'd2}); end
        n_vec++; if (dut.u_sram.lru_q[0] !== 1'b1) begin n_err++; $display("FAIL wb_lru: got %b want 1", dut.u_sram.lru_q[0]); end
    endtask

    task automatic test_clean_eviction();
        int st; logic [31:0] q; logic to; int rd0, wc0;
        cpu_op(1'b1, 1'b0, 32'h020, 32'h0, st, q, to);
        cpu_op(1'b1, 1'b0, 32'h220, 32'h0, st, q, to);
        rd0 = rd_count; wc0 = write_cycles;
        cpu_op(1'b1, 1'b0, 32'h420, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0 || st != CLEAN_STALL) begin n_err++; $display("FAIL clean_stall: got %0d want %0d", st, CLEAN_STALL); end
        n_vec++; if (q !== 32'h4200CAFE) begin n_err++; $display("FAIL clean_data: got %h want 4200cafe", q); end
        n_vec++; if (write_cycles != wc0) begin n_err++; $display("FAIL clean_no_write: got %0d write cycles want 0", write_cycles - wc0); end
        n_vec++; if (rd_count - rd0 != 1) begin n_err++; $display("FAIL clean_one_refill: got %0d want 1", rd_count - rd0); end
        n_vec++; if (dut.u_sram.tag_q[1][0] !== {2'b10, 23'd2}) begin n_err++; $display("FAIL clean_victim_way0: got %h want %h", dut.u_sram.tag_q[1][0], {2'b10, 23'd2}); end
    endtask

    task automatic test_reset_in_readmiss();
        int st; logic [31:0] q; logic to; logic seen;
        mem_auto = 1'b0;
        @(negedge clk_i);
        cpu_addr_i = 32'h040; cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            #1;
            if (mem_enable_o && !mem_write_o) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rst_refill_request: refill request not seen"); end
        n_vec++; if (mem_addr_o !== 32'h040) begin n_err++; $display("FAIL rst_refill_addr: got %h want 00000040", mem_addr_o); end
        #1;
        rst_i = 1'b1;
        #1;
        n_vec++; if (mem_enable_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_enable: got %b want 0", mem_enable_o); end
        n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        // A late ack from the aborted refill must be ignored.
        #2 force_ack = 1'b1;
        @(negedge clk_i);
        #2 force_ack = 1'b0;
        @(negedge clk_i);
        #1;
        n_vec++; if (dut.state_q !== ST_IDLE || mem_enable_o !== 1'b0) begin n_err++; $display("FAIL rst_late_ack: state %0d enable %b want %0d 0", dut.state_q, mem_enable_o, ST_IDLE); end
        n_vec++; if (dut.u_sram.tag_q[2][0][VALID_BIT] !== 1'b0 || dut.u_sram.tag_q[0][0][VALID_BIT] !== 1'b0 || dut.u_sram.tag_q[1][1][VALID_BIT] !== 1'b0) begin n_err++; $display("FAIL rst_entries_invalid: got %b%b%b want 000", dut.u_sram.tag_q[2][0][VALID_BIT], dut.u_sram.tag_q[0][0][VALID_BIT], dut.u_sram.tag_q[1][1][VALID_BIT]); end
        mem_auto = 1'b1;
        cpu_op(1'b1, 1'b0, 32'h000, 32'h0, st, q, to);
        n_vec++; if (to !== 1'b0 || st != CLEAN_STALL) begin n_err++; $display("FAIL rst_next_load_miss: got %0d want %0d", st, CLEAN_STALL); end
        n_vec++; if (q !== 32'hEEEEFFFF) begin n_err++; $display("FAIL rst_next_load_data: got %h want eeeeffff", q); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_load_hit();
        test_store_hit();
        test_writeback();
        test_clean_eviction();
        test_reset_in_readmiss();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- 2-way set-associative, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-based data memory.
- Serves 32-bit loads and stores from the pipeline and stalls the pipeline on a miss.
- Handles line refill and dirty-victim write-back through a single-outstanding enable/ack handshake with memory.
- Replaces lines by per-set 1-bit LRU.

Parameters:
- NUM_SETS, 16, number of sets; index width is log2(NUM_SETS) = 4.
- LINE_BITS, 256, cache line and memory beat width (32 bytes).
- TAG_BITS, 23, address tag width, taken from addr[31:9].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- cpu_addr_i  in  32  byte address; [4:2] word select, [8:5] index, [31:9] tag; [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data; valid when cpu_stall_o=0.
- cpu_stall_o  out  1  freezes the pipeline while the current request misses.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  1-cycle pulse; memory completed the request.
- mem_data_o  out  256  write-back line.
- mem_addr_o  out  32  line address, [4:0]=0.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = write-back, 0 = refill.

Behaviour:
- Tag entry is 25 bits: [24] valid, [23] dirty, [22:0] tag.
- Hit is combinational: req = MemRead|MemWrite; hit = req & (way0 or way1 is valid with matching tag).
- cpu_stall_o = req & ~hit, combinational, in every state.
- If MemRead and MemWrite are both high, the request is treated as a store.
- Load hit: cpu_data_o = hit line[word*32 +: 32], word = addr[4:2], same cycle.
- Store hit: at the clock edge, merge cpu_data_i into that word of the hit way and set dirty.
- On any hit, the LRU bit of the set is set to the other way.
- Victim selection: first invalid way (way0 preferred); if both ways are valid, the way named by LRU.
- FSM states: IDLE=0, MISS=1, READMISS=2, READMISSOK=3, WRITEBACK=4.
  - IDLE: if req & ~hit, go to MISS.
  - MISS: if the victim is valid & dirty, go to WRITEBACK with enable=1, write=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. Otherwise go to READMISS with enable=1, write=0, mem_addr_o={addr[31:5], 5'b0}.
  - WRITEBACK: hold all outputs until mem_ack_i=1, then go to READMISS with enable=1, write=0, refill address.
  - READMISS: hold until mem_ack_i=1; then enable=0, write mem_data_i into the victim way (valid=1, dirty=0, new tag), go to READMISSOK.
  - READMISSOK: go to IDLE. The next cycle, the request hits and is served as a normal hit (a store merges and sets dirty).
- The request's addr, data and op are held stable by the pipeline while stalled, so the controller needs no request latch.
- mem_enable_o / mem_write_o / mem_addr_o / mem_data_o are registered and stable while enable=1. mem_ack_i outside READMISS/WRITEBACK is ignored.
- Miss latency is 3 cycles plus memory latency (clean victim), or plus 2× memory latency (dirty victim).
- Reset values (asynchronous, may occur mid-transaction): state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, all tags=0 (invalid), all data=0, all LRU=0. cpu_data_o=0 and cpu_stall_o=0 follow combinationally.
- After reset, any in-flight memory ack is dropped.

Decomposition:
- Shared package holds:
  - state encodings (IDLE..WRITEBACK);
  - field widths: OFFSET_W=5, INDEX_W=4, TAG_W=23, ENTRY_W=25;
  - tag-entry bit positions VALID_BIT=24, DIRTY_BIT=23.
- One sub-module: dcache_sram_2way holds tag[16][2], data[16][2] and LRU[16], and produces the hit compare, hit way, victim way and victim entry.
- The controller holds the FSM and the memory handshake.

Test Plan:
- Cold load: mem line 0 = 0x0000_1111_…_EEEE_FFFF; load 0x000 → stall through refill, then cpu_data_o=0xEEEEFFFF; entry valid=1, dirty=0; no mem write seen.
- Load hit: after the cold load, load 0x01C → no stall, cpu_data_o=0x00001111 same cycle; LRU[0]=1.
- Store hit: store 0xDEADBEEF to 0x004 → no stall; line[63:32]=0xDEADBEEF; dirty=1; memory unchanged.
- Conflict with write-back: fill set 0 with 0x000 (dirty) and 0x200 (clean); load 0x400 → WRITEBACK to mem_addr 0x000 with the modified line, then refill from 0x400; cpu_data_o=0xE00EF00F. Way0 is replaced and LRU points to way1.
- Clean eviction: with both ways of set 1 clean, load a third tag → no mem_write_o=1 cycle; exactly one refill request.
- Reset in READMISS: assert rst_i mid-refill → mem_enable_o=0 and state=IDLE immediately; a late mem_ack_i is ignored; all entries invalid; the next load misses.
